exposure_timer: RTL and testbench
=================================

Name: exposure_timer

Overview:
- Upstream stage of the exposure/readout control FSM.
- Holds the user-programmable exposure time, adjusted by increase and decrease buttons.
- Times the exposure window while Expose is high, then emits the single-cycle Ovf5 pulse that ends the exposure and starts pixel readout.
- Single clock domain; the button inputs are asynchronous to it.

Parameters:
- EXP_W, 5, width of the exposure value register.
- EXP_MIN, 2, lowest exposure value in units.
- EXP_MAX, 30, highest exposure value in units.
- EXP_RESET, 15, exposure value after reset.
- TICKS_PER_UNIT, 1000, Clk cycles per exposure unit (1 ms at 1 MHz).
- TICK_W, 10, prescaler width; must satisfy 2^TICK_W >= TICKS_PER_UNIT.
- DEB_CYCLES, 4, stable-high cycles required to accept a press (optional feature only).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Expose  in  1  exposure-active level from the control FSM; its rising edge starts timing.
- Exp_increase  in  1  asynchronous button; one press raises the value by 1.
- Exp_decrease  in  1  asynchronous button; one press lowers the value by 1.
- Ovf5  out  1  exposure-complete pulse, one Clk cycle wide.
- Busy  out  1  high while timing or waiting for Expose to drop.
- Exp_value  out  EXP_W  current programmed exposure value.

Behaviour:
- Reset (asynchronous, active-high) forces the following; Reset mid-count abandons the exposure with no Ovf5:
  - state = IDLE
  - Exp_value = EXP_RESET
  - Ovf5 = 0, Busy = 0
  - prescaler = 0, remaining = 0
  - synchronizer and edge flops = 0
- Button path:
  - Each button passes a 2-flop synchronizer, then a rising-edge detector.
  - A press is accepted 3 Clk edges after the raw button rises; it yields exactly one step per press.
- Adjustments are applied only in IDLE.
  - Increase press: Exp_value + 1, saturating at EXP_MAX.
  - Decrease press: Exp_value - 1, saturating at EXP_MIN.
  - Both presses in the same cycle: no change.
  - Presses during COUNT or DONE are discarded, not queued.
- Expose is sampled into Expose_d each cycle; start = Expose & ~Expose_d.
- IDLE:
  - On start: remaining <= Exp_value, prescaler <= 0, go to COUNT.
  - A button press in the same cycle as start is discarded.
- COUNT (Busy = 1):
  - Prescaler counts 0..TICKS_PER_UNIT-1 and wraps.
  - On each wrap, remaining decrements.
  - On the wrap where remaining == 1: Ovf5 = 1 for that one cycle, go to DONE.
  - Ovf5 is registered and asserts exactly Exp_value*TICKS_PER_UNIT cycles after the cycle in which start was seen.
  - Expose low in COUNT (abort): go to IDLE, no Ovf5, counters cleared.
- DONE (Busy = 1, Ovf5 = 0 after its single cycle):
  - Wait for Expose low, then go to IDLE.
  - A new exposure needs a fresh rising edge of Expose.
- Exp_value is always within EXP_MIN..EXP_MAX; its width never overflows because EXP_MAX < 2^EXP_W.
- Arithmetic is unsigned; the remaining counter is EXP_W wide.

Optional Feature:
- Macro: EXPOSURE_TIMER_DEBOUNCE_EN.
- Defined:
  - After the synchronizer, each button must be high for DEB_CYCLES consecutive cycles before a press is registered.
  - The press is registered once per high period.
  - Acceptance latency is 2 + DEB_CYCLES Clk edges.
  - Glitches shorter than DEB_CYCLES produce no step.
- Undefined: synchronizer plus edge detect only, 3-edge latency; every synchronized rising edge counts.

Decomposition:
- Package exposure_timer_pkg holds:
  - the state enum (IDLE, COUNT, DONE)
  - EXP_MIN, EXP_MAX and EXP_RESET defaults
  - the default TICKS_PER_UNIT.
- Sub-module btn_pulse, instantiated twice, one per button:
  - 2-flop synchronizer
  - optional debounce counter under EXPOSURE_TIMER_DEBOUNCE_EN
  - rising-edge one-shot output.
- The FSM, prescaler and value register live in the top module.

Test Plan (bench uses TICKS_PER_UNIT=4, macro undefined unless noted):
- Reset, then idle 10 cycles -> Exp_value=15, Ovf5=0, Busy=0 throughout.
- Three increase presses, 5 cycles each -> Exp_value 18. Then 20 decrease presses -> Exp_value stops at 2, never 1 or wrap.
- Exp_value=2, raise Expose and hold -> Busy=1 next cycle; Ovf5 high for exactly one cycle, 8 cycles after start. Drop Expose -> Busy=0 next cycle.
- Expose rises, falls after 5 cycles with Exp_value=3 (12-cycle window) -> no Ovf5, Busy=0. Immediate re-raise restarts a full 12-cycle count.
- Increase press during COUNT, and increase+decrease in the same IDLE cycle -> Exp_value unchanged in both cases.
- Reset asserted at cycle 6 of a 60-cycle exposure -> outputs at reset values immediately, no Ovf5. With the macro defined and DEB_CYCLES=4, a 2-cycle button glitch -> no step; a 6-cycle press -> exactly one step.

Source files
------------

// File: rtl/exposure_timer_pkg.sv
// Shared types and default configuration for the exposure timer.
package exposure_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int EXP_MIN_DEFAULT        = 2;
    localparam int EXP_MAX_DEFAULT        = 30;
    localparam int EXP_RESET_DEFAULT      = 15;
    localparam int TICKS_PER_UNIT_DEFAULT = 1000;

endpackage

// File: rtl/exposure_timer_if.sv
// Control/status bundle between the exposure FSM and the exposure timer.
interface exposure_timer_if #(
    parameter int EXP_W = 5
);
    import exposure_timer_pkg::*;

    logic             Expose;
    logic             Exp_increase;
    logic             Exp_decrease;
    logic             Ovf5;
    logic             Busy;
    logic [EXP_W-1:0] Exp_value;

    // Controller side: drives exposure level and buttons, observes status.
    modport master (
        output Expose, Exp_increase, Exp_decrease,
        input  Ovf5, Busy, Exp_value
    );

    // Timer side.
    modport slave (
        input  Expose, Exp_increase, Exp_decrease,
        output Ovf5, Busy, Exp_value
    );
endinterface

// File: rtl/exposure_timer_btn_pulse.sv
// Button conditioner: 2-flop synchronizer, then a one-shot press pulse.
// With EXPOSURE_TIMER_DEBOUNCE_EN defined the synchronized level must stay
// high DEB_CYCLES cycles before the pulse fires (latency 2 + DEB_CYCLES);
// otherwise every synchronized rising edge is a press (latency 3).
module btn_pulse
    import exposure_timer_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
`ifdef EXPOSURE_TIMER_DEBOUNCE_EN
    localparam int DEB_N = DEB_CYCLES;
`else
    // One stable sample is enough; the counter degenerates to an edge flop.
    localparam int DEB_N = 1 + 0 * DEB_CYCLES;
`endif
    localparam int CNT_W = $clog2(DEB_N + 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // High-run counter, saturating so one high period gives one pulse.
    always_comb begin
        cnt_d = '0;
        if (sync2_q)
            cnt_d = (cnt_q == CNT_W'(DEB_N)) ? cnt_q : cnt_q + CNT_W'(1);
    end

    assign press = sync2_q && (cnt_q == CNT_W'(DEB_N - 1));

    // Synchronizer and run counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: holds the programmable exposure value, times the exposure
// window while Expose is high and emits a one-cycle Ovf5 at its end.
// Optional button debounce: EXPOSURE_TIMER_DEBOUNCE_EN.
module exposure_timer
    import exposure_timer_pkg::*;
#(
    parameter int EXP_W          = 5,
    parameter int EXP_MIN        = EXP_MIN_DEFAULT,
    parameter int EXP_MAX        = EXP_MAX_DEFAULT,
    parameter int EXP_RESET      = EXP_RESET_DEFAULT,
    parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEFAULT,
    parameter int TICK_W         = 10,
    parameter int DEB_CYCLES     = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    exposure_timer_if.slave   bus
);
    logic inc_press, dec_press;

    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
        .clk(Clk), .rst(Reset), .btn(bus.Exp_increase), .press(inc_press)
    );
    btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_dec (
        .clk(Clk), .rst(Reset), .btn(bus.Exp_decrease), .press(dec_press)
    );

    state_e            state_q, state_d;
    logic [EXP_W-1:0]  exp_value_q, exp_value_d;
    logic [EXP_W-1:0]  remaining_q, remaining_d;
    logic [TICK_W-1:0] prescaler_q, prescaler_d;
    logic              expose_d_q, expose_d_d;
    logic              ovf5_q, ovf5_d;
    logic              busy_q, busy_d;
    logic              start, wrap;

    assign start = bus.Expose & ~expose_d_q;
    assign wrap  = (prescaler_q == TICK_W'(TICKS_PER_UNIT - 1));

    // Next-state logic: value adjust in IDLE, unit countdown in COUNT.
    always_comb begin
        state_d     = state_q;
        exp_value_d = exp_value_q;
        remaining_d = remaining_q;
        prescaler_d = prescaler_q;
        expose_d_d  = bus.Expose;
        ovf5_d      = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // A press coinciding with start is dropped.
                    state_d     = COUNT;
                    remaining_d = exp_value_q;
                    prescaler_d = '0;
                    busy_d      = 1'b1;
                end else if (inc_press && !dec_press) begin
                    if (exp_value_q < EXP_W'(EXP_MAX))
                        exp_value_d = exp_value_q + EXP_W'(1);
                end else if (dec_press && !inc_press) begin
                    if (exp_value_q > EXP_W'(EXP_MIN))
                        exp_value_d = exp_value_q - EXP_W'(1);
                end
            end
            COUNT: begin
                if (!bus.Expose) begin
                    // Abort: no Ovf5, counters cleared.
                    state_d     = IDLE;
                    remaining_d = '0;
                    prescaler_d = '0;
                    busy_d      = 1'b0;
                end else if (wrap) begin
                    prescaler_d = '0;
                    if (remaining_q == EXP_W'(1)) begin
                        ovf5_d      = 1'b1;
                        remaining_d = '0;
                        state_d     = DONE;
                    end else begin
                        remaining_d = remaining_q - EXP_W'(1);
                    end
                end else begin
                    prescaler_d = prescaler_q + TICK_W'(1);
                end
            end
            DONE: begin
                if (!bus.Expose) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            exp_value_q <= EXP_W'(EXP_RESET);
            remaining_q <= '0;
            prescaler_q <= '0;
            expose_d_q  <= 1'b0;
            ovf5_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_value_q <= exp_value_d;
            remaining_q <= remaining_d;
            prescaler_q <= prescaler_d;
            expose_d_q  <= expose_d_d;
            ovf5_q      <= ovf5_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.Ovf5      = ovf5_q;
    assign bus.Busy      = busy_q;
    assign bus.Exp_value = exp_value_q;
endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer with TICKS_PER_UNIT = 4.
module tb_exposure_timer;
    import exposure_timer_pkg::*;

    localparam int EXP_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exposure_timer_if #(.EXP_W(EXP_W)) bus();

    exposure_timer #(
        .EXP_W(EXP_W), .EXP_MIN(2), .EXP_MAX(30), .EXP_RESET(15),
        .TICKS_PER_UNIT(4), .TICK_W(2), .DEB_CYCLES(4)
    ) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef enum {OP_INC, OP_DEC, OP_BOTH} op_e;
    typedef struct {
        op_e op;
        int  n;
        int  exp_val;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic press(input op_e op, input int hold);
        @(negedge clk);
        bus.Exp_increase = (op != OP_DEC);
        bus.Exp_decrease = (op != OP_INC);
        repeat (hold) @(negedge clk);
        bus.Exp_increase = 1'b0;
        bus.Exp_decrease = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // Hold Expose from a fresh rising edge; expect Ovf5 exactly n edges after the start edge.
    task automatic timed_exposure(input string name, input int n);
        @(negedge clk);
        bus.Expose = 1'b1;
        @(posedge clk); #1;
        check({name, "_busy_start"}, bus.Busy, 1);
        for (int i = 1; i <= n + 3; i++) begin
            @(posedge clk); #1;
            check({name, "_ovf"}, bus.Ovf5, (i == n) ? 1 : 0);
        end
        check({name, "_busy_done"}, bus.Busy, 1);
        @(negedge clk);
        bus.Expose = 1'b0;
        @(posedge clk); #1;
        check({name, "_busy_drop"}, bus.Busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf_seen;
        int bad;

        vecs[0] = '{OP_INC,  3,  18};
        vecs[1] = '{OP_BOTH, 1,  18};
        vecs[2] = '{OP_INC,  20, 30};
        vecs[3] = '{OP_DEC,  1,  29};
        vecs[4] = '{OP_DEC,  30, 2};

        bus.Expose = 1'b0;
        bus.Exp_increase = 1'b0;
        bus.Exp_decrease = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state held over 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("reset_value", bus.Exp_value, 15);
            check("reset_ovf", bus.Ovf5, 0);
            check("reset_busy", bus.Busy, 0);
        end

        // Button vectors, including saturation at both ends
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].n; k++) begin
                press(vecs[v].op, 5);
                check("value_in_range",
                      (bus.Exp_value >= 2 && bus.Exp_value <= 30) ? 1 : 0, 1);
            end
            check($sformatf("vec%0d_value", v), bus.Exp_value, vecs[v].exp_val);
        end

        // Value 2: Ovf5 8 edges after start, Busy held in DONE
        timed_exposure("exp2", 8);

        // Value 3, abort after 5 cycles
        press(OP_INC, 5);
        check("value_3", bus.Exp_value, 3);
        @(negedge clk);
        bus.Expose = 1'b1;
        ovf_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.Ovf5) ovf_seen = 1;
        end
        bus.Expose = 1'b0;
        @(posedge clk); #1;
        if (bus.Ovf5) ovf_seen = 1;
        check("abort_busy", bus.Busy, 0);
        check("abort_no_ovf", ovf_seen, 0);
        // Immediate re-raise gets a full 12-cycle count
        timed_exposure("restart", 12);

        // Increase press during COUNT is discarded
        @(negedge clk);
        bus.Expose = 1'b1;
        @(negedge clk);
        bus.Exp_increase = 1'b1;
        repeat (4) @(negedge clk);
        bus.Exp_increase = 1'b0;
        ovf_seen = 0;
        for (int i = 0; i < 20 && ovf_seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.Ovf5) ovf_seen = 1;
        end
        check("count_ovf_seen", ovf_seen, 1);
        @(negedge clk);
        bus.Expose = 1'b0;
        repeat (3) @(negedge clk);
        check("press_in_count", bus.Exp_value, 3);

        // Reset mid-way through a 60-cycle exposure
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rereset_value", bus.Exp_value, 15);
        @(negedge clk);
        bus.Expose = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_busy", bus.Busy, 0);
        check("midreset_ovf", bus.Ovf5, 0);
        check("midreset_value", bus.Exp_value, 15);
        @(negedge clk);
        bus.Expose = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (bus.Ovf5 || bus.Busy) bad = 1;
        end
        check("midreset_quiet", bad, 0);

        // Short glitch and long press
        press(OP_INC, 2);
`ifdef EXPOSURE_TIMER_DEBOUNCE_EN
        check("glitch_value", bus.Exp_value, 15);
        press(OP_INC, 6);
        check("long_press_value", bus.Exp_value, 16);
`else
        check("glitch_value", bus.Exp_value, 16);
        press(OP_INC, 6);
        check("long_press_value", bus.Exp_value, 17);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
